// File: rtl/fifo_write_ctrl.sv
// Write-side controller for a single-clock RAM FIFO: drives the RAM write port,
// tracks occupancy from read-side pop strobes and reports status/sticky errors.
module fifo_write_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int AF_LEVEL = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] w_add,
    output logic              w_en,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH;
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL;
    localparam logic [ADDR_W:0] CNT_ONE = 1;
    localparam logic [ADDR_W:0] CNT_ZERO = 0;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   w_add_q, w_add_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                af_q, af_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                accept, pop_ok;

    // Status flags decode the registered state directly.
    assign empty       = (state_q == S_EMPTY);
    assign full        = (state_q == S_FULL);
    assign w_add       = w_add_q;
    assign w_en        = w_en_q;
    assign w_data      = w_data_q;
    assign count       = count_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

    always_comb begin
        accept   = push && (!full || pop);
        pop_ok   = pop && !empty;
        wptr_d   = wptr_q;
        w_add_d  = w_add_q;
        w_data_d = w_data_q;
        w_en_d   = accept;
        count_d  = count_q;
        state_d  = state_q;

        if (accept) begin
            w_add_d  = wptr_q;
            w_data_d = wdata;
            wptr_d   = wptr_q + PTR_ONE;
        end

        if (accept && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !accept) begin
            count_d = count_q - CNT_ONE;
        end

        af_d = (count_d >= AF_C);

        // A set event wins over a clear sampled on the same edge.
        ovf_d = (push && !accept) ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        udf_d = (pop && !pop_ok)  ? 1'b1 : (clr_err ? 1'b0 : udf_q);

        case (state_q)
            S_EMPTY: begin
                if (count_d == DEPTH_C)       state_d = S_FULL;
                else if (count_d != CNT_ZERO) state_d = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (count_d == DEPTH_C)       state_d = S_FULL;
                else if (count_d == CNT_ZERO) state_d = S_EMPTY;
            end
            S_FULL: begin
                if (count_d == CNT_ZERO)      state_d = S_EMPTY;
                else if (count_d != DEPTH_C)  state_d = S_PARTIAL;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            wptr_q   <= '0;
            w_add_q  <= '0;
            w_data_q <= '0;
            w_en_q   <= 1'b0;
            count_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            w_add_q  <= w_add_d;
            w_data_q <= w_data_d;
            w_en_q   <= w_en_d;
            count_q  <= count_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed and randomized bench for fifo_write_ctrl against an occupancy/pointer
// reference model built from integer arithmetic.
module tb_fifo_write_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int AF_LEVEL = 14;
    localparam int DEPTH = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              pop;
    logic              clr_err;
    logic [ADDR_W-1:0] w_add;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cnt;
    int          m_ptr;
    int          m_wadd;
    logic [7:0]  m_wdata;
    bit          m_wen;
    bit          m_ovf;
    bit          m_udf;

    fifo_write_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .wdata(wdata),
        .pop(pop),
        .clr_err(clr_err),
        .w_add(w_add),
        .w_en(w_en),
        .w_data(w_data),
        .count(count),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ptr = 0; m_wadd = 0; m_wdata = 8'h00;
        m_wen = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_edge(input bit p, input logic [7:0] d, input bit q, input bit c);
        bit fl, em, acc, pok;
        fl  = (m_cnt == DEPTH);
        em  = (m_cnt == 0);
        acc = p && (!fl || q);
        pok = q && !em;
        m_wen = acc;
        if (acc) begin
            m_wadd  = m_ptr;
            m_wdata = d;
            m_ptr   = (m_ptr + 1) % DEPTH;
        end
        m_cnt = m_cnt + int'(acc) - int'(pok);
        if (p && !acc) m_ovf = 1;
        else if (c)    m_ovf = 0;
        if (q && !pok) m_udf = 1;
        else if (c)    m_udf = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w_en"},   32'(w_en),        32'(m_wen));
        chk({tag, ".w_add"},  32'(w_add),       32'(m_wadd));
        chk({tag, ".w_data"}, 32'(w_data),      32'(m_wdata));
        chk({tag, ".count"},  32'(count),       32'(m_cnt));
        chk({tag, ".empty"},  32'(empty),       32'(m_cnt == 0));
        chk({tag, ".full"},   32'(full),        32'(m_cnt == DEPTH));
        chk({tag, ".af"},     32'(almost_full), 32'(m_cnt >= AF_LEVEL));
        chk({tag, ".ovf"},    32'(overflow),    32'(m_ovf));
        chk({tag, ".udf"},    32'(underflow),   32'(m_udf));
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic step(input string tag, input bit p, input logic [7:0] d, input bit q, input bit c);
        push = p; wdata = d; pop = q; clr_err = c;
        @(posedge clk);
        model_edge(p, d, q, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        push = 0; wdata = '0; pop = 0; clr_err = 0; reset = 0;
        model_reset();

        // Asynchronous reset takes effect before any clock edge
        #3 reset = 1;
        #1 check_all("reset");
        @(posedge clk); #1;
        reset = 0;

        // 1: single push
        step("t1_push", 1, 8'hA5, 0, 0);
        chk("t1_wen_const", 32'(w_en), 32'd1);
        chk("t1_wdata_const", 32'(w_data), 32'hA5);
        step("t1_idle", 0, 8'h00, 0, 0);
        chk("t1_wen_low", 32'(w_en), 32'd0);
        step("t1_drain", 0, 8'h00, 1, 0);

        // 2: sixteen pushes to full, then a rejected 17th
        for (int i = 0; i < 16; i++) step("t2_fill", 1, 8'(i), 0, 0);
        chk("t2_full_const", 32'(full), 32'd1);
        step("t2_over", 1, 8'hEE, 0, 0);
        chk("t2_ovf_const", 32'(overflow), 32'd1);
        chk("t2_cnt_const", 32'(count), 32'd16);

        // 3: push+pop on full, then lone pop
        step("t3_pushpop", 1, 8'h3C, 1, 0);
        chk("t3_full_hold", 32'(full), 32'd1);
        step("t3_pop", 0, 8'h00, 1, 0);
        chk("t3_cnt_const", 32'(count), 32'd15);

        // 4: underflow and clearing
        for (int i = 0; i < 15; i++) step("t4_drain", 0, 8'h00, 1, 0);
        step("t4_udf", 0, 8'h00, 1, 0);
        chk("t4_udf_const", 32'(underflow), 32'd1);
        step("t4_clr", 0, 8'h00, 0, 1);
        chk("t4_clr_const", 32'(underflow), 32'd0);
        step("t4_prio", 0, 8'h00, 1, 1);
        chk("t4_prio_const", 32'(underflow), 32'd1);
        step("t4_clr2", 0, 8'h00, 0, 1);

        // 5: fill/drain and wrap while interleaving
        for (int i = 0; i < 5; i++) step("t5_push", 1, 8'(8'h50 + i), 0, 0);
        for (int i = 0; i < 5; i++) step("t5_pop", 0, 8'h00, 1, 0);
        chk("t5_empty_const", 32'(empty), 32'd1);
        for (int i = 0; i < 20; i++) step("t5_inter", (i % 2) == 0, 8'(i), (i % 2) == 1, 0);

        // 6: reset in the middle of a burst at count 9
        for (int i = 0; i < 9; i++) step("t6_push", 1, 8'(8'h90 + i), 0, 0);
        chk("t6_cnt9", 32'(count), 32'd9);
        push = 1; wdata = 8'h77;
        #2 reset = 1;
        model_reset();
        #1 check_all("t6_async");
        @(posedge clk); #1;
        check_all("t6_held");
        reset = 0; push = 0;
        step("t6_first", 1, 8'h12, 0, 0);
        chk("t6_wadd0", 32'(w_add), 32'd0);

        // Randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            int pp, pq;
            pp = ((i / 100) % 2 == 0) ? 75 : 30;
            pq = ((i / 100) % 2 == 0) ? 30 : 75;
            step("rand", $urandom_range(99) < pp, 8'($urandom),
                 $urandom_range(99) < pq, $urandom_range(99) < 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
